// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the synchronous data RAM block.
//   - state_t   : controller FSM encoding (ST_INIT clears the array, ST_IDLE serves requests)
//   - RWN_*     : request direction encoding on req_rwn (1 = read, 0 = write)
//   - even_par  : even-parity helper used when RAM_PARITY_EN is defined
package ram_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  localparam logic RWN_READ  = 1'b1;
  localparam logic RWN_WRITE = 1'b0;

  // Parity helper takes a zero-extended word; zero padding does not change parity.
  localparam int PAR_MAX_W = 64;

  function automatic logic even_par(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ram_sync_array.sv
// ram_sync_array: DEPTH x WW storage with a synchronous write port and a
// registered read port sharing one address.
// Ports:
//   clk   : clock
//   rst   : asynchronous active-high reset (clears the read register only)
//   we    : write enable, mem[addr] <= wdata on the rising edge
//   addr  : word address (only the low $clog2(DEPTH) bits index the array;
//           the caller guarantees addr < DEPTH whenever we, or re without rzero, is high)
//   wdata : write data
//   re    : read enable, rdata is loaded on the rising edge
//   rzero : with re, load zero instead of array contents (out-of-range read)
//   rdata : registered read data, held until the next re
module ram_sync_array #(
  parameter int DW    = 4,
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int WW    = DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [WW-1:0] wdata,
  input  logic          re,
  input  logic          rzero,
  output logic [WW-1:0] rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WW-1:0] mem_r [0:DEPTH-1];
  logic [IW-1:0] idx_s;
  logic [WW-1:0] rdata_r;

  assign idx_s = addr[IW-1:0];
  assign rdata = rdata_r;

  // Storage array: plain synchronous write, no reset (contents cleared by the controller).
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[idx_s] <= wdata;
    end
  end

  // Read register: loads on a read request and holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= {WW{1'b0}};
    end else if (re) begin
      if (rzero) begin
        rdata_r <= {WW{1'b0}};
      end else begin
        rdata_r <= mem_r[idx_s];
      end
    end
  end

endmodule

// File: rtl/ram_sync_ctrl.sv
// ram_sync_ctrl: clocked single-port data RAM with valid/ready requests,
// one-cycle read latency and a hardware clear engine.
// Optional feature macro: RAM_PARITY_EN (per-word even parity, error injection
// via wr_par_flip and parity check reported on rsp_perr). Parity needs DW <= 64.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   clr         : level request to re-zero the array (only honoured in IDLE)
//   req_valid   : request present;  req_ready : request accepted this cycle
//   req_rwn     : 1 = read, 0 = write
//   req_addr    : word address;  req_din : write data
//   rsp_valid   : one-cycle pulse, dout carries read data
//   dout        : read data, held until the next read response
//   rsp_oor     : one-cycle pulse after an accepted out-of-range request
//   init_done   : high while the array is usable (IDLE)
//   wr_par_flip : (RAM_PARITY_EN) invert the stored parity bit of this write
//   rsp_perr    : (RAM_PARITY_EN) parity mismatch on the returned word
module ram_sync_ctrl
  import ram_pkg::*;
#(
  parameter int DW    = 4,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_rwn,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_din,
  output logic          rsp_valid,
  output logic [DW-1:0] dout,
  output logic          rsp_oor,
  output logic          init_done
`ifdef RAM_PARITY_EN
  ,
  input  logic          wr_par_flip,
  output logic          rsp_perr
`endif
);

`ifdef RAM_PARITY_EN
  localparam int WW = DW + 1;
`else
  localparam int WW = DW;
`endif

  // Pointer is one bit wider than the address so DEPTH == 2**AW does not wrap.
  localparam int          PW      = AW + 1;
  localparam logic [AW:0] DEPTH_W = PW'(DEPTH);
  localparam logic [AW:0] LAST_W  = PW'(DEPTH - 1);

  state_t        state_r;
  state_t        state_nx_s;
  logic [AW:0]   ptr_r;
  logic [AW:0]   ptr_nx_s;

  logic          ready_s;
  logic          accept_s;
  logic          rd_acc_s;
  logic          wr_acc_s;
  logic          oor_s;
  logic          we_s;
  logic [AW-1:0] addr_s;
  logic [WW-1:0] wdata_s;
  logic [WW-1:0] rdata_s;
  logic          rsp_valid_r;
  logic          rsp_oor_r;

  assign oor_s    = ({1'b0, req_addr} >= DEPTH_W);
  assign accept_s = req_valid & ready_s;
  assign rd_acc_s = accept_s & (req_rwn == RWN_READ);
  assign wr_acc_s = accept_s & (req_rwn == RWN_WRITE);

  // FSM state register and clear pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_INIT;
      ptr_r   <= {PW{1'b0}};
    end else begin
      state_r <= state_nx_s;
      ptr_r   <= ptr_nx_s;
    end
  end

  // FSM next-state: INIT walks ptr over every word, IDLE returns to INIT on clr.
  always_comb begin
    state_nx_s = state_r;
    ptr_nx_s   = {PW{1'b0}};
    case (state_r)
      ST_INIT: begin
        if (ptr_r == LAST_W) begin
          state_nx_s = ST_IDLE;
          ptr_nx_s   = {PW{1'b0}};
        end else begin
          state_nx_s = ST_INIT;
          ptr_nx_s   = ptr_r + {{AW{1'b0}}, 1'b1};
        end
      end
      ST_IDLE: begin
        ptr_nx_s = {PW{1'b0}};
        if (clr) begin
          state_nx_s = ST_INIT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      default: begin
        state_nx_s = ST_INIT;
        ptr_nx_s   = {PW{1'b0}};
      end
    endcase
  end

  // FSM outputs: handshake and array write port steering.
  always_comb begin
    ready_s   = 1'b0;
    init_done = 1'b0;
    we_s      = 1'b0;
    addr_s    = req_addr;
    wdata_s   = {WW{1'b0}};
    case (state_r)
      ST_INIT: begin
        // Clear engine owns the array; parity bit of a zero word is 0.
        we_s    = 1'b1;
        addr_s  = ptr_r[AW-1:0];
        wdata_s = {WW{1'b0}};
      end
      ST_IDLE: begin
        init_done = 1'b1;
        ready_s   = ~clr;
        we_s      = wr_acc_s & ~oor_s;
        addr_s    = req_addr;
`ifdef RAM_PARITY_EN
        wdata_s   = {even_par(PAR_MAX_W'(req_din)) ^ wr_par_flip, req_din};
`else
        wdata_s   = req_din;
`endif
      end
      default: begin
        we_s = 1'b0;
      end
    endcase
  end

  // Response flags: one-cycle pulses registered on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_oor_r   <= 1'b0;
    end else begin
      rsp_valid_r <= rd_acc_s;
      rsp_oor_r   <= accept_s & oor_s;
    end
  end

  ram_sync_array #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW),
    .WW    (WW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (we_s),
    .addr  (addr_s),
    .wdata (wdata_s),
    .re    (rd_acc_s),
    .rzero (oor_s),
    .rdata (rdata_s)
  );

  assign req_ready = ready_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_oor   = rsp_oor_r;
  assign dout      = rdata_s[DW-1:0];

`ifdef RAM_PARITY_EN
  // Stored parity bit versus parity recomputed over the returned data.
  assign rsp_perr = rdata_s[DW] ^ even_par(PAR_MAX_W'(rdata_s[DW-1:0]));
`endif

endmodule

// File: tb/tb_ram_sync_ctrl.sv
// Directed bench: two instances share one stimulus stream, a (DEPTH=16) and
// b (DEPTH=12), so out-of-range behaviour and clear length are compared side by side.
module tb_ram_sync_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       req_valid;
  logic       req_rwn;
  logic [3:0] req_addr;
  logic [3:0] req_din;

  logic       a_ready, a_valid, a_oor, a_done;
  logic [3:0] a_dout;
  logic       b_ready, b_valid, b_oor, b_done;
  logic [3:0] b_dout;
`ifdef RAM_PARITY_EN
  logic       wr_par_flip;
  logic       a_perr, b_perr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_sync_ctrl #(.DW(4), .DEPTH(16), .AW(4)) u_dut_a (
    .clk(clk), .rst(rst), .clr(clr),
    .req_valid(req_valid), .req_ready(a_ready), .req_rwn(req_rwn),
    .req_addr(req_addr), .req_din(req_din),
    .rsp_valid(a_valid), .dout(a_dout), .rsp_oor(a_oor), .init_done(a_done)
`ifdef RAM_PARITY_EN
    , .wr_par_flip(wr_par_flip), .rsp_perr(a_perr)
`endif
  );

  ram_sync_ctrl #(.DW(4), .DEPTH(12), .AW(4)) u_dut_b (
    .clk(clk), .rst(rst), .clr(clr),
    .req_valid(req_valid), .req_ready(b_ready), .req_rwn(req_rwn),
    .req_addr(req_addr), .req_din(req_din),
    .rsp_valid(b_valid), .dout(b_dout), .rsp_oor(b_oor), .init_done(b_done)
`ifdef RAM_PARITY_EN
    , .wr_par_flip(wr_par_flip), .rsp_perr(b_perr)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rwn, input logic [3:0] a, input logic [3:0] d);
    req_valid = v;
    req_rwn   = rwn;
    req_addr  = a;
    req_din   = d;
  endtask

  initial begin
    logic [3:0] exp_d;
    rst = 1'b1; clr = 1'b0;
    drive(1'b0, 1'b1, 4'd0, 4'd0);
`ifdef RAM_PARITY_EN
    wr_par_flip = 1'b0;
`endif
    #12;
    // Reset state
    chk("rst_a_ready", a_ready, 0); chk("rst_a_valid", a_valid, 0);
    chk("rst_a_dout", a_dout, 0);   chk("rst_a_oor", a_oor, 0);
    chk("rst_a_done", a_done, 0);   chk("rst_b_done", b_done, 0);
    chk("rst_b_ready", b_ready, 0);
    rst = 1'b0;

    // Clear after reset: 16 cycles for a, 12 for b
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("init_a_done%0d", k), a_done, (k == 16) ? 1 : 0);
      chk($sformatf("init_a_ready%0d", k), a_ready, (k == 16) ? 1 : 0);
      chk($sformatf("init_b_done%0d", k), b_done, (k >= 12) ? 1 : 0);
    end

    // Read sweep 0..15 back-to-back: all zero, b flags 12..15 out of range
    for (int a = 0; a < 16; a++) begin
      drive(1'b1, 1'b1, 4'(a), 4'd0);
      tick();
      chk($sformatf("sweep_a_valid%0d", a), a_valid, 1);
      chk($sformatf("sweep_a_dout%0d", a), a_dout, 0);
      chk($sformatf("sweep_a_oor%0d", a), a_oor, 0);
      chk($sformatf("sweep_b_valid%0d", a), b_valid, 1);
      chk($sformatf("sweep_b_oor%0d", a), b_oor, (a >= 12) ? 1 : 0);
    end

    // Writes 0..3 = 1..4: no response, dout unchanged
    for (int a = 0; a < 4; a++) begin
      drive(1'b1, 1'b0, 4'(a), 4'(a + 1));
      tick();
      chk($sformatf("wr_a_valid%0d", a), a_valid, 0);
      chk($sformatf("wr_a_dout%0d", a), a_dout, 0);
    end
    // Reads 3,2,1,0 back-to-back
    for (int a = 3; a >= 0; a--) begin
      drive(1'b1, 1'b1, 4'(a), 4'd0);
      tick();
      exp_d = 4'(a + 1);
      chk($sformatf("rb_a_valid%0d", a), a_valid, 1);
      chk($sformatf("rb_a_dout%0d", a), a_dout, exp_d);
      chk($sformatf("rb_b_dout%0d", a), b_dout, exp_d);
    end
    drive(1'b0, 1'b1, 4'd0, 4'd0);
    tick();
    chk("idle_a_valid", a_valid, 0);
    chk("idle_a_dout_hold", a_dout, 4'd1);

    // Read immediately after write
    drive(1'b1, 1'b0, 4'd5, 4'd9);
    tick();
    drive(1'b1, 1'b1, 4'd5, 4'd0);
    tick();
    chk("raw_a_valid", a_valid, 1);
    chk("raw_a_dout", a_dout, 4'd9);
    chk("raw_b_dout", b_dout, 4'd9);

    // Address 13: in range for a, out of range for b
    drive(1'b1, 1'b0, 4'd13, 4'd7);
    tick();
    chk("oorw_a_oor", a_oor, 0);
    chk("oorw_b_oor", b_oor, 1);
    chk("oorw_b_valid", b_valid, 0);
    drive(1'b1, 1'b1, 4'd13, 4'd0);
    tick();
    chk("oorr_a_dout", a_dout, 4'd7);
    chk("oorr_a_oor", a_oor, 0);
    chk("oorr_b_valid", b_valid, 1);
    chk("oorr_b_dout", b_dout, 0);
    chk("oorr_b_oor", b_oor, 1);
    drive(1'b1, 1'b1, 4'd1, 4'd0);
    tick();
    chk("alias_b_dout", b_dout, 4'd2);
    chk("alias_b_oor", b_oor, 0);

    // Read accepted just before clr, then clr together with a request
    drive(1'b1, 1'b1, 4'd2, 4'd0);
    tick();
    chk("preclr_a_dout", a_dout, 4'd3);
    clr = 1'b1;
    drive(1'b1, 1'b1, 4'd1, 4'd0);
    #1;
    chk("clr_a_ready", a_ready, 0);
    chk("clr_b_ready", b_ready, 0);
    tick();
    chk("clr_a_valid", a_valid, 0);
    chk("clr_a_dout_hold", a_dout, 4'd3);
    chk("clr_a_done", a_done, 0);
    chk("clr_b_done", b_done, 0);
    clr = 1'b0;
    drive(1'b0, 1'b1, 4'd0, 4'd0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("reinit_a_done%0d", k), a_done, (k == 16) ? 1 : 0);
      chk($sformatf("reinit_b_done%0d", k), b_done, (k >= 12) ? 1 : 0);
    end
    for (int a = 0; a < 4; a++) begin
      drive(1'b1, 1'b1, 4'(a), 4'd0);
      tick();
      chk($sformatf("cleared_a_dout%0d", a), a_dout, 0);
      chk($sformatf("cleared_b_dout%0d", a), b_dout, 0);
    end
    drive(1'b1, 1'b1, 4'd5, 4'd0);
    tick();
    chk("cleared_a_dout5", a_dout, 0);

    // Reset in the middle of back-to-back reads
    drive(1'b1, 1'b0, 4'd2, 4'd6);
    tick();
    drive(1'b1, 1'b1, 4'd2, 4'd0);
    tick();
    chk("prerst_a_dout", a_dout, 4'd6);
    tick();
    chk("prerst_a_valid", a_valid, 1);
    #2 rst = 1'b1;
    drive(1'b0, 1'b1, 4'd0, 4'd0);
    #1;
    chk("midrst_a_valid", a_valid, 0);
    chk("midrst_b_valid", b_valid, 0);
    chk("midrst_a_dout", a_dout, 0);
    chk("midrst_a_done", a_done, 0);
    chk("midrst_a_ready", a_ready, 0);
    #3 rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("rstinit_a_done%0d", k), a_done, (k == 16) ? 1 : 0);
    end
    drive(1'b1, 1'b1, 4'd2, 4'd0);
    tick();
    chk("rstclr_a_valid", a_valid, 1);
    chk("rstclr_a_dout", a_dout, 0);

`ifdef RAM_PARITY_EN
    // Parity error injection
    wr_par_flip = 1'b1;
    drive(1'b1, 1'b0, 4'd6, 4'd5);
    tick();
    wr_par_flip = 1'b0;
    drive(1'b1, 1'b1, 4'd6, 4'd0);
    tick();
    chk("par_a_dout", a_dout, 4'd5);
    chk("par_a_perr", a_perr, 1);
    chk("par_b_perr", b_perr, 1);
    drive(1'b1, 1'b0, 4'd7, 4'd3);
    tick();
    drive(1'b1, 1'b1, 4'd7, 4'd0);
    tick();
    chk("par_ok_a_perr", a_perr, 0);
    chk("par_ok_b_perr", b_perr, 0);
`endif

    drive(1'b0, 1'b1, 4'd0, 4'd0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
